multi_time_base: RTL

Parametrised, runtime-programmable multi-channel enable-pulse generator: N_CH independent down-counters, each producing a one-cycle pulse every DIV clock cycles. The divisors are programmed over a simple write port. The block replaces the fixed three-rate time base: it feeds display multiplexing, game-tick and UI-timing enables across the design. It adds per-channel one-shot mode, a global hold enable and a synchronous phase-realignment input.

---
 rtl/multi_time_base.sv | 77 +++++++
 1 files changed

// File: rtl/multi_time_base.sv
// Purpose: N_CH programmable enable-pulse generators (periodic or one-shot) with hold and phase realign.
// Latency: pulse is registered; a write takes effect on the next edge, first pulse div enabled edges later.
// Backpressure: none; writes always accepted, enable=0 freezes counters and forces pulses low.
module multi_time_base #(
  parameter int N_CH        = 3,
  parameter int DIV_W       = 26,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sync,
  input  logic             wr_en,
  input  logic [3:0]       wr_ch,
  input  logic [DIV_W-1:0] wr_div,
  input  logic             wr_oneshot,
  output logic [N_CH-1:0]  pulse,
  output logic [N_CH-1:0]  active
);

  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  logic [DIV_W-1:0] div_q [N_CH];
  logic [DIV_W-1:0] cnt_q [N_CH];
  logic [N_CH-1:0]  oneshot_q;
  logic [DIV_W-1:0] wr_div_eff;
  logic [N_CH-1:0]  wr_hit;

  // Clamp a zero divisor to 1 and decode which channel (if any) the write targets;
  // an out-of-range wr_ch matches no channel, so the write is dropped.
  always_comb begin
    wr_div_eff = (wr_div == '0) ? ONE : wr_div;
    wr_hit     = '0;
    for (int i = 0; i < N_CH; i++) begin
      wr_hit[i] = wr_en && (wr_ch == 4'(i));
    end
  end

  // Per-channel down-counter: reset > write > sync > count; a pulse fires as the count wraps.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (reset) begin
        div_q[i]     <= DEF_DIV;
        cnt_q[i]     <= DEF_DIV - ONE;
        oneshot_q[i] <= 1'b0;
        active[i]    <= 1'b1;
        pulse[i]     <= 1'b0;
      end else if (wr_hit[i]) begin
        div_q[i]     <= wr_div_eff;
        cnt_q[i]     <= wr_div_eff - ONE;
        oneshot_q[i] <= wr_oneshot;
        active[i]    <= 1'b1;
        pulse[i]     <= 1'b0;
      end else if (sync && active[i]) begin
        cnt_q[i] <= div_q[i] - ONE;
        pulse[i] <= 1'b0;
      end else if (enable && active[i]) begin
        if (cnt_q[i] == '0) begin
          pulse[i] <= 1'b1;
          cnt_q[i] <= div_q[i] - ONE;
          // One-shot channels disarm on the same edge that raises their pulse.
          if (oneshot_q[i]) begin
            active[i] <= 1'b0;
          end
        end else begin
          pulse[i] <= 1'b0;
          cnt_q[i] <= cnt_q[i] - ONE;
        end
      end else begin
        // Held or disarmed: counter frozen, no pulse.
        pulse[i] <= 1'b0;
      end
    end
  end

endmodule
